// File: rtl/seq_nibble_multiplier_if.sv
// Operand/result handshake bundle for seq_nibble_multiplier.
// The producer side drives operands and takes results (master);
// the multiplier consumes operands and presents results (slave).
interface seq_nibble_multiplier_if #(
    parameter int A_WIDTH  = 16,
    parameter int B_DIGITS = 4
);
    localparam int P_WIDTH = A_WIDTH + 4 * B_DIGITS;

    logic                    in_valid;
    logic                    in_ready;
    logic [A_WIDTH-1:0]      a;
    logic [4*B_DIGITS-1:0]   b;
    logic                    out_valid;
    logic                    out_ready;
    logic [P_WIDTH-1:0]      result;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/seq_nibble_multiplier.sv
// Multi-cycle signed multiplier: retires one 4-bit digit of b per clock.
// Lower digits are unsigned; the top digit is signed and its partial
// product is subtracted (two's complement of the magnitude product).
module seq_nibble_multiplier #(
    parameter int A_WIDTH  = 16,
    parameter int B_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    arst,
    seq_nibble_multiplier_if.slave  bus,
    output logic                    busy
);
    localparam int P_WIDTH = A_WIDTH + 4 * B_DIGITS;
    localparam int CNT_W   = (B_DIGITS > 1) ? $clog2(B_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(B_DIGITS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]              state;
    logic [A_WIDTH-1:0]      a_reg;
    logic [4*B_DIGITS-1:0]   b_reg;
    logic [P_WIDTH-1:0]      acc;
    logic [CNT_W-1:0]        cnt;

    logic [3:0]              digit;
    logic                    top_digit;
    logic                    digit_neg;
    logic [3:0]              digit_mag;
    logic [P_WIDTH-1:0]      a_sext;
    logic [P_WIDTH-1:0]      pp_mag;
    logic [P_WIDTH-1:0]      pp;
    logic [P_WIDTH-1:0]      pp_shifted;

    // Partial product of the current digit, aligned to its digit position.
    // A top digit of -8 has magnitude 8, which still fits the 4-bit field.
    always_comb begin
        digit      = b_reg[{cnt, 2'b00} +: 4];
        top_digit  = (cnt == LAST_DIGIT);
        digit_neg  = top_digit && digit[3];
        digit_mag  = digit_neg ? (4'd0 - digit) : digit;
        a_sext     = P_WIDTH'($signed(a_reg));
        pp_mag     = a_sext * {{(P_WIDTH-4){1'b0}}, digit_mag};
        pp         = digit_neg ? ('0 - pp_mag) : pp_mag;
        pp_shifted = pp << {cnt, 2'b00};
    end

    // Control FSM, operand capture and digit-serial accumulation.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= ST_IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc + pp_shifted;
                    if (top_digit) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status flags are decoded from state alone.
    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
        busy          = (state == ST_RUN) || (state == ST_DONE);
        bus.result    = acc;
    end
endmodule

// File: tb/tb_seq_nibble_multiplier.sv
// Scoreboard bench for seq_nibble_multiplier: accepted operand pairs push
// their signed product; a monitor pops and compares on each result handshake.
module tb_seq_nibble_multiplier;
    localparam int A_W = 16;
    localparam int B_D = 4;
    localparam int P_W = A_W + 4 * B_D;
    localparam int LAT = B_D + 1;
    localparam int GAP = B_D + 2;

    logic clk;
    logic arst;
    logic busy;

    seq_nibble_multiplier_if #(.A_WIDTH(A_W), .B_DIGITS(B_D)) bus ();

    seq_nibble_multiplier #(.A_WIDTH(A_W), .B_DIGITS(B_D)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus.slave),
        .busy (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [P_W-1:0] exp_q[$];
    int             acc_cyc_q[$];

    bit             b2b = 0;
    bit             have_last = 0;
    int             last_acc_cyc = 0;

    bit             held = 0;
    logic [P_W-1:0] held_result;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [P_W-1:0] model(input logic [A_W-1:0] av, input logic [4*B_D-1:0] bv);
        longint p;
        p = longint'($signed(av)) * longint'($signed(bv));
        return p[P_W-1:0];
    endfunction

    // Acceptance tracker: records the expected product of every accepted pair.
    always @(negedge clk) begin
        if (!arst && bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.a, bus.b));
            acc_cyc_q.push_back(cyc);
            if (b2b) begin
                if (have_last) check("accept_spacing", 64'(cyc - last_acc_cyc), 64'(GAP));
                have_last = 1;
                last_acc_cyc = cyc;
            end else begin
                have_last = 0;
            end
        end
    end

    // Result monitor: latency, hold stability, flag coherence and value check.
    always @(negedge clk) begin
        if (arst) begin
            exp_q.delete();
            acc_cyc_q.delete();
            held = 0;
        end else begin
            check("ready_vs_busy", 64'(bus.in_ready), 64'(!busy));
            if (bus.out_valid) begin
                if (!held) begin
                    if (acc_cyc_q.size() == 0) fail("stale_out_valid");
                    else check("latency", 64'(cyc - acc_cyc_q.pop_front()), 64'(LAT));
                end else begin
                    check("hold_stable", 64'(bus.result), 64'(held_result));
                end
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) fail("result_without_accept");
                    else check("product", 64'(bus.result), 64'(exp_q.pop_front()));
                    held = 0;
                end else begin
                    held = 1;
                    held_result = bus.result;
                end
            end
        end
    end

    // Present an operand pair (called at posedge+1) and wait for its accept edge.
    task automatic send(input logic [A_W-1:0] av, input logic [4*B_D-1:0] bv, input bit keep);
        int unsigned n;
        n = 0;
        bus.a = av;
        bus.b = bv;
        bus.in_valid = 1;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) fail("accept_timeout");
        @(posedge clk); #1;
        if (!keep) bus.in_valid = 0;
    endtask

    task automatic wait_valid();
        int unsigned n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) fail("out_valid_timeout");
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_result"}, 64'(bus.result), 64'(0));
    endtask

    initial begin
        arst = 1;
        bus.in_valid = 0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        arst = 0;

        // Basic transaction with timing checks.
        send(16'd3, 16'd5, 0);
        check("in_ready_after_accept", 64'(bus.in_ready), 64'(0));
        wait_valid();
        @(posedge clk); #1;
        check("idle_after_take", 64'(bus.in_ready), 64'(1));

        // Sign corner cases.
        send(16'hFFFF, 16'h0001, 0);
        send(16'h0001, 16'h8000, 0);
        send(16'h8000, 16'h8000, 0);
        send(16'h7FFF, 16'h8000, 0);
        drain();

        // Hold result in DONE while inputs churn.
        bus.out_ready = 0;
        send(16'($urandom), 16'($urandom), 0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.in_valid = ~bus.in_valid;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            check("hold_in_ready", 64'(bus.in_ready), 64'(0));
            check("hold_out_valid", 64'(bus.out_valid), 64'(1));
        end
        bus.in_valid = 1;
        bus.out_ready = 1;
        @(posedge clk); #1;
        check("done_no_accept_ready", 64'(bus.in_ready), 64'(1));
        check("done_no_accept_busy", 64'(busy), 64'(0));
        bus.in_valid = 0;
        drain();

        // Back-to-back random traffic.
        b2b = 1;
        for (int i = 0; i < 100; i++) begin
            send(16'($urandom), 16'($urandom), 1);
        end
        bus.in_valid = 0;
        b2b = 0;
        drain();

        // Abort in the second RUN cycle.
        send(16'h1234, 16'h5678, 0);
        @(posedge clk); #1;
        arst = 1;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        arst = 0;
        @(posedge clk); #1;
        send(16'd2, 16'hFFFD, 0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end
endmodule
